// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared 8-source bus mux.
// Grants are one-hot, separated by a dead TURN cycle, with an optional hold limit.
module bus_arbiter #(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [2:0]       sel,
  output logic             busy,
  output logic [7:0]       hold_cnt
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  localparam logic [7:0] HoldLimit = 8'(MAX_HOLD);

  state_t     r_state;
  logic [2:0] r_lastOwner;
  logic [2:0] w_winner;
  logic       w_anyReq;
  logic       w_others;
  logic       w_exit;

  // Walk the search order backwards so the highest-priority requester is assigned last;
  // k = N_REQ lands on the previous owner itself, which is searched last.
  always_comb begin
    w_winner = r_lastOwner;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[r_lastOwner + 3'(k)]) begin
        w_winner = r_lastOwner + 3'(k);
      end
    end
  end

  assign w_anyReq = |req;
  assign w_others = |(req & ~(N_REQ'(1) << r_lastOwner));
  assign w_exit   = !req[r_lastOwner] ||
                    ((MAX_HOLD != 0) && (hold_cnt >= HoldLimit) && w_others);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_lastOwner <= 3'd7;
      gnt         <= '0;
      sel         <= 3'd0;
      busy        <= 1'b0;
      hold_cnt    <= 8'd0;
    end else begin
      case (r_state)
        IDLE, TURN: begin
          if (w_anyReq) begin
            r_state     <= GRANT;
            r_lastOwner <= w_winner;
            gnt         <= N_REQ'(1) << w_winner;
            sel         <= w_winner;
            busy        <= 1'b1;
            hold_cnt    <= 8'd1;
          end else begin
            r_state  <= IDLE;
            gnt      <= '0;
            busy     <= 1'b0;
            hold_cnt <= 8'd0;
          end
        end
        GRANT: begin
          if (w_exit) begin
            r_state  <= TURN;
            gnt      <= '0;
            busy     <= 1'b0;
            hold_cnt <= 8'd0;
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          r_state  <= IDLE;
          gnt      <= '0;
          busy     <= 1'b0;
          hold_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, single owner, round-robin, wrap priority,
// hand-off, ignored pulses and reset during a grant.
module tb_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic [7:0] hold_cnt;

  int checks;
  int errors;

  bus_arbiter #(.N_REQ(8), .MAX_HOLD(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .sel      (sel),
    .busy     (busy),
    .hold_cnt (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    req = 8'h00;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 8'h00;
    tick();
    tick();
    checks++;
    if ({gnt, sel, busy, hold_cnt} !== {8'h00, 3'd0, 1'b0, 8'd0}) begin
      errors++;
      $display("[TB] FAIL reset_values: gnt=%h sel=%0d busy=%b hold=%0d expected 00/0/0/0",
               gnt, sel, busy, hold_cnt);
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({gnt, sel, busy, hold_cnt} !== {8'h00, 3'd0, 1'b0, 8'd0}) begin
        errors++;
        $display("[TB] FAIL idle_after_reset c%0d: gnt=%h sel=%0d busy=%b hold=%0d expected 00/0/0/0",
                 c, gnt, sel, busy, hold_cnt);
      end
    end
  endtask

  task automatic test_single_request();
    doReset();
    req = 8'h20;
    for (int c = 1; c <= 10; c++) begin
      tick();
      checks++;
      if ({gnt, sel, busy, hold_cnt} !== {8'h20, 3'd5, 1'b1, 8'(c)}) begin
        errors++;
        $display("[TB] FAIL single_grant c%0d: gnt=%h sel=%0d busy=%b hold=%0d expected 20/5/1/%0d",
                 c, gnt, sel, busy, hold_cnt, c);
      end
    end
    req = 8'h00;
    tick();
    checks++;
    if ({gnt, sel, busy, hold_cnt} !== {8'h00, 3'd5, 1'b0, 8'd0}) begin
      errors++;
      $display("[TB] FAIL single_turn: gnt=%h sel=%0d busy=%b hold=%0d expected 00/5/0/0",
               gnt, sel, busy, hold_cnt);
    end
    tick();
    checks++;
    if ({gnt, sel, busy, hold_cnt} !== {8'h00, 3'd5, 1'b0, 8'd0}) begin
      errors++;
      $display("[TB] FAIL single_idle: gnt=%h sel=%0d busy=%b hold=%0d expected 00/5/0/0",
               gnt, sel, busy, hold_cnt);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] expGnt;
    logic [2:0] owner;
    doReset();
    req = 8'hFF;
    for (int n = 0; n < 9; n++) begin
      owner  = 3'(n);
      expGnt = 8'h01 << owner;
      for (int h = 1; h <= 4; h++) begin
        tick();
        checks++;
        if ({gnt, sel, busy, hold_cnt} !== {expGnt, owner, 1'b1, 8'(h)}) begin
          errors++;
          $display("[TB] FAIL rr_grant n%0d h%0d: gnt=%h sel=%0d busy=%b hold=%0d expected %h/%0d/1/%0d",
                   n, h, gnt, sel, busy, hold_cnt, expGnt, owner, h);
        end
        if (n == 8) break;
      end
      if (n == 8) break;
      tick();
      checks++;
      if ({gnt, sel, busy, hold_cnt} !== {8'h00, owner, 1'b0, 8'd0}) begin
        errors++;
        $display("[TB] FAIL rr_turn n%0d: gnt=%h sel=%0d busy=%b hold=%0d expected 00/%0d/0/0",
                 n, gnt, sel, busy, hold_cnt, owner);
      end
    end
    req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_wrap_priority();
    doReset();
    req = 8'h40;
    tick();
    req = 8'h00;
    tick();
    tick();
    req = 8'h41;
    tick();
    checks++;
    if ({gnt, sel, busy} !== {8'h01, 3'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL wrap_zero_first: gnt=%h sel=%0d busy=%b expected 01/0/1", gnt, sel, busy);
    end
    req = 8'h40;
    tick();
    checks++;
    if ({gnt, sel, busy} !== {8'h00, 3'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL wrap_turn: gnt=%h sel=%0d busy=%b expected 00/0/0", gnt, sel, busy);
    end
    tick();
    checks++;
    if ({gnt, sel, busy, hold_cnt} !== {8'h40, 3'd6, 1'b1, 8'd1}) begin
      errors++;
      $display("[TB] FAIL wrap_six_next: gnt=%h sel=%0d busy=%b hold=%0d expected 40/6/1/1",
               gnt, sel, busy, hold_cnt);
    end
    req = 8'h00;
    tick();
    req = 8'h40;
    tick();
    checks++;
    if ({gnt, sel, busy, hold_cnt} !== {8'h40, 3'd6, 1'b1, 8'd1}) begin
      errors++;
      $display("[TB] FAIL wrap_sole_regain: gnt=%h sel=%0d busy=%b hold=%0d expected 40/6/1/1",
               gnt, sel, busy, hold_cnt);
    end
    req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_handoff();
    doReset();
    req = 8'h04;
    tick();
    checks++;
    if ({gnt, sel} !== {8'h04, 3'd2}) begin
      errors++;
      $display("[TB] FAIL handoff_owner2: gnt=%h sel=%0d expected 04/2", gnt, sel);
    end
    req = 8'h08;
    tick();
    checks++;
    if ({gnt, sel, busy} !== {8'h00, 3'd2, 1'b0}) begin
      errors++;
      $display("[TB] FAIL handoff_turn: gnt=%h sel=%0d busy=%b expected 00/2/0", gnt, sel, busy);
    end
    tick();
    checks++;
    if ({gnt, sel, busy, hold_cnt} !== {8'h08, 3'd3, 1'b1, 8'd1}) begin
      errors++;
      $display("[TB] FAIL handoff_owner3: gnt=%h sel=%0d busy=%b hold=%0d expected 08/3/1/1",
               gnt, sel, busy, hold_cnt);
    end
    // A short request from source 5 while 3 owns the bus must be forgotten.
    req = 8'h28;
    tick();
    checks++;
    if ({gnt, sel, hold_cnt} !== {8'h08, 3'd3, 8'd2}) begin
      errors++;
      $display("[TB] FAIL pulse_no_preempt: gnt=%h sel=%0d hold=%0d expected 08/3/2", gnt, sel, hold_cnt);
    end
    req = 8'h00;
    tick();
    tick();
    checks++;
    if ({gnt, sel, busy} !== {8'h00, 3'd3, 1'b0}) begin
      errors++;
      $display("[TB] FAIL pulse_forgotten: gnt=%h sel=%0d busy=%b expected 00/3/0", gnt, sel, busy);
    end
  endtask

  task automatic test_reset_mid_grant();
    doReset();
    req = 8'h10;
    tick();
    tick();
    tick();
    checks++;
    if ({gnt, sel, hold_cnt} !== {8'h10, 3'd4, 8'd3}) begin
      errors++;
      $display("[TB] FAIL midrst_setup: gnt=%h sel=%0d hold=%0d expected 10/4/3", gnt, sel, hold_cnt);
    end
    rst = 1'b1;
    req = 8'h30;
    tick();
    checks++;
    if ({gnt, sel, busy, hold_cnt} !== {8'h00, 3'd0, 1'b0, 8'd0}) begin
      errors++;
      $display("[TB] FAIL midrst_cleared: gnt=%h sel=%0d busy=%b hold=%0d expected 00/0/0/0",
               gnt, sel, busy, hold_cnt);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({gnt, sel, busy, hold_cnt} !== {8'h10, 3'd4, 1'b1, 8'd1}) begin
      errors++;
      $display("[TB] FAIL midrst_regrant: gnt=%h sel=%0d busy=%b hold=%0d expected 10/4/1/1",
               gnt, sel, busy, hold_cnt);
    end
    req = 8'h00;
    tick();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    req    = 8'h00;
    test_reset();
    test_single_request();
    test_round_robin();
    test_wrap_priority();
    test_handoff();
    test_reset_mid_grant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Round-robin arbiter and sequencer for the shared 8-source, 8-bit data bus multiplexer. It takes one request line per bus source and issues a one-hot grant. It drives the 3-bit mux select so that exactly one source owns the bus at a time. A hold limit with a one-cycle turnaround between owners keeps any source from starving the others.

Parameters:
- N_REQ, 8, number of requesters. Fixed at 8 to match the 3-bit bus select; other values are unsupported.
- MAX_HOLD, 4, maximum consecutive grant cycles while another request is pending. 0 means no limit. Legal range 0..255.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- req, input, 8, req[i] high means source i requests the bus. Level-sensitive; held for as long as the bus is wanted.
- gnt, output, 8, one-hot grant; gnt[i] high means source i owns the bus this cycle. All zero when nobody owns the bus.
- sel, output, 3, bus mux select; equals the binary index of the current owner.
- busy, output, 1, high whenever gnt is non-zero.
- hold_cnt, output, 8, number of cycles the current owner has held the grant, for debug and bench use.

Behaviour:
- One clock, synchronous active-high reset. Reset takes effect on the first rising edge with rst=1 and overrides all other inputs.
- All outputs are registered.
- Reset values:
  - gnt=0, sel=0, busy=0, hold_cnt=0.
  - Internal last_owner=7, so source 0 has top priority after reset.
  - State=IDLE.
- States: IDLE, GRANT, TURN.
- Arbitration function, evaluated in IDLE and TURN:
  - Search req starting at index last_owner+1 mod 8, ascending with wrap.
  - The first set bit wins.
  - The previous owner is searched last, so it can regain the bus only when it is the sole requester.
- IDLE:
  - gnt=0, busy=0; sel keeps its last value.
  - If req!=0, go to GRANT with the winner. gnt/sel/busy are valid on the next cycle, i.e. 1-cycle latency from req to gnt.
  - On entry to GRANT: hold_cnt=1, last_owner=winner.
- GRANT:
  - gnt[owner]=1, sel=owner, busy=1.
  - hold_cnt increments each cycle, saturating at 255.
  - Exit to TURN on the next edge when either condition holds:
    - (a) req[owner]=0, or
    - (b) MAX_HOLD!=0, hold_cnt>=MAX_HOLD, and (req with bit owner cleared)!=0.
  - Otherwise stay in GRANT. With no competitor, the owner keeps the bus indefinitely.
- TURN:
  - Exactly one dead cycle: gnt=0, busy=0, hold_cnt=0; sel holds the old owner.
  - Arbitration runs this cycle. If req!=0, go to GRANT with the winner; else go to IDLE.
- Guarantees:
  - gnt is never multi-hot.
  - gnt never changes directly from one owner to another without a TURN cycle between.
  - sel changes only on entry to GRANT.
- Boundary cases:
  - Wrap-around: with last_owner=7, the search order is 0,1,…,7.
  - Simultaneous events: the owner dropping req and a new req rising in the same cycle gives one TURN, then the new owner.
  - A request pulse present only during a GRANT cycle of another source and gone by TURN is not served and is not remembered.
  - Reset mid-GRANT: the next edge forces the reset values, gnt=0 immediately.
  - MAX_HOLD=1 with two requesters: grants alternate 1 cycle on, 1 TURN cycle, then the next requester.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, req=0 -> gnt=0, sel=0, busy=0, hold_cnt=0, FSM stays in IDLE.
2. Single request: req=8'h20 from cycle 0 -> gnt=8'h20, sel=5, busy=1 at cycle 1. hold_cnt counts 1,2,3… with no preemption past MAX_HOLD. Dropping req at cycle 10 -> TURN at 11, IDLE at 12.
3. Round-robin fairness: after reset, req=8'hFF held continuously, MAX_HOLD=4 -> grants cycle through owners 0,1,2,…,7,0. Each owner holds for 4 cycles, separated by one TURN cycle.
4. Wrap priority: last owner 6, then req=8'h41 -> owner 0 wins before 6. If req=8'h40 only -> owner 6 regains after TURN.
5. Simultaneous hand-off: owner 2 drops req in the same cycle that req[3] rises -> one TURN cycle, then gnt=8'h08, sel=3. gnt is never 8'h0C.
6. Reset mid-grant: owner 4 at hold_cnt=3, rst pulsed 1 cycle with req=8'h30 held -> gnt=0 after the reset edge. The next grant goes to source 4, searched from last_owner=7.
